// File: rtl/main_memory_responder.sv
// Main-memory side of the cache <-> memory link: 16-word line fills and single-word
// write-through writes against a word-addressed backing store, with programmable wait states.
module main_memory_responder #(
    parameter int DEPTH_WORDS   = 4096,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  main_mem_addr,
    input  logic [31:0]  main_mem_data_out,
    input  logic         main_mem_read_req,
    input  logic         main_mem_write_req,
    output logic [511:0] main_mem_data_in,
    output logic         main_mem_ready,
    output logic         busy,
    output logic         protocol_err
);
    localparam int AW   = $clog2(DEPTH_WORDS);
    localparam int MAXL = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CW   = (MAXL > 1) ? $clog2(MAXL + 1) : 1;

    typedef enum logic [2:0] {IDLE, FILL, RWAIT, WWAIT, RESP} state_t;
    typedef logic [31:0] mem_t [DEPTH_WORDS];

    function automatic mem_t mem_init();
        mem_t m;
        for (int i = 0; i < DEPTH_WORDS; i++) m[i] = 32'(i);
        return m;
    endfunction

    // Power-up image: word i holds i. Never cleared by reset.
    mem_t mem_q = mem_init();

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      beat_q, beat_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [511:0]    line_q;
    logic            ready_q, busy_q, err_q, err_d;
    logic [AW-1:0]   idx;
    logic [31:0]     rd_word;
    logic            unused_addr_bits;

    assign idx              = main_mem_addr[AW+1:2];
    assign unused_addr_bits = ^{main_mem_addr[31:AW+2], main_mem_addr[1:0]};
    // Line base has its low 4 bits cleared, so base+beat never carries past the line.
    assign rd_word          = mem_q[addr_q + AW'(beat_q)];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (main_mem_read_req) begin
                    addr_d  = idx & ~AW'(15);
                    beat_d  = 4'd0;
                    state_d = FILL;
                    err_d   = main_mem_write_req;
                end else if (main_mem_write_req) begin
                    addr_d  = idx;
                    wdata_d = main_mem_data_out;
                    cnt_d   = CW'(WRITE_LATENCY);
                    state_d = WWAIT;
                end
            end
            FILL: begin
                beat_d = beat_q + 4'd1;
                if (beat_q == 4'd15) begin
                    if (READ_LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        // One wait cycle is already spent on the edge that enters RWAIT.
                        cnt_d   = CW'(READ_LATENCY - 1);
                        state_d = RWAIT;
                    end
                end
            end
            RWAIT, WWAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - CW'(1);
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE) err_d = main_mem_read_req | main_mem_write_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= (state_d == RESP);
            busy_q  <= (state_d != IDLE);
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                line_q                    <= '0;
        else if (state_q == FILL)  line_q[{beat_q, 5'd0} +: 32] <= rd_word;
    end

    // Commit lands on the same edge that raises ready.
    always_ff @(posedge clk) begin
        if (state_q == WWAIT && cnt_q == '0) mem_q[addr_q] <= wdata_q;
    end

    assign main_mem_data_in = line_q;
    assign main_mem_ready   = ready_q;
    assign busy             = busy_q;
    assign protocol_err     = err_q;
endmodule

// File: tb/tb_main_memory_responder.sv
// Directed + randomized checks of main_memory_responder against an array model of the store.
module tb_main_memory_responder;
    localparam int DEPTH = 4096;
    localparam int RL    = 4;
    localparam int WL    = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  main_mem_addr = '0;
    logic [31:0]  main_mem_data_out = '0;
    logic         main_mem_read_req = 1'b0;
    logic         main_mem_write_req = 1'b0;
    logic [511:0] main_mem_data_in;
    logic         main_mem_ready;
    logic         busy;
    logic         protocol_err;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    int rdy_cnt = 0;
    logic [31:0]  model [DEPTH];
    logic [511:0] last_line = '0;

    main_memory_responder #(
        .DEPTH_WORDS(DEPTH), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .main_mem_addr(main_mem_addr), .main_mem_data_out(main_mem_data_out),
        .main_mem_read_req(main_mem_read_req), .main_mem_write_req(main_mem_write_req),
        .main_mem_data_in(main_mem_data_in), .main_mem_ready(main_mem_ready),
        .busy(busy), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (protocol_err)   err_cnt++;
            if (main_mem_ready) rdy_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] model_line(input logic [31:0] a);
        logic [511:0] l;
        int base;
        base = int'((a >> 2) % DEPTH) & ~15;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = model[(base + k) % DEPTH];
        return l;
    endfunction

    // Waits for the ready pulse after E0; returns cycles counted from E0.
    task automatic wait_ready(input int inj, output int n, output bit busy_ok);
        n = 0;
        busy_ok = 1'b1;
        while (!main_mem_ready && n < 100) begin
            if (!busy) busy_ok = 1'b0;
            main_mem_read_req = (inj != 0 && n == inj);
            @(negedge clk);
            n++;
        end
        main_mem_read_req = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input bit both, input int inj, input string tag);
        int n, e0, r0;
        bit bok;
        logic [511:0] exp_line;
        exp_line = model_line(a);
        e0 = err_cnt;
        r0 = rdy_cnt;
        @(negedge clk);
        main_mem_addr = a;
        main_mem_data_out = 32'h55;
        main_mem_read_req = 1'b1;
        main_mem_write_req = both;
        @(negedge clk);
        main_mem_read_req = 1'b0;
        main_mem_write_req = 1'b0;
        wait_ready(inj, n, bok);
        chk({tag, " latency"}, 512'(n), 512'(16 + RL));
        chk({tag, " busy"}, 512'(bok), 512'(1));
        chk({tag, " line"}, main_mem_data_in, exp_line);
        @(negedge clk);
        chk({tag, " after ready/busy"}, {main_mem_ready, busy}, 2'b00);
        #1;
        chk({tag, " perr pulses"}, 512'(err_cnt - e0), 512'((both || inj != 0) ? 1 : 0));
        chk({tag, " ready pulses"}, 512'(rdy_cnt - r0), 512'(1));
        last_line = exp_line;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input string tag);
        int n, e0, r0;
        bit bok;
        e0 = err_cnt;
        r0 = rdy_cnt;
        @(negedge clk);
        main_mem_addr = a;
        main_mem_data_out = d;
        main_mem_write_req = 1'b1;
        @(negedge clk);
        main_mem_write_req = 1'b0;
        wait_ready(0, n, bok);
        chk({tag, " latency"}, 512'(n), 512'(1 + WL));
        chk({tag, " busy"}, 512'(bok), 512'(1));
        model[(a >> 2) % DEPTH] = d;
        @(negedge clk);
        chk({tag, " after ready/busy"}, {main_mem_ready, busy}, 2'b00);
        #1;
        chk({tag, " perr pulses"}, 512'(err_cnt - e0), 512'(0));
        chk({tag, " ready pulses"}, 512'(rdy_cnt - r0), 512'(1));
        chk({tag, " line held"}, main_mem_data_in, last_line);
    endtask

    initial begin
        int r0;
        logic [31:0] a, d;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'(i);

        #1;
        chk("reset outputs", {main_mem_data_in, main_mem_ready, busy, protocol_err}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_read(32'h0000_0040, 1'b0, 0, "T1");
        chk("T1 word0", 512'(main_mem_data_in[31:0]), 512'(32'h10));
        chk("T1 word15", 512'(main_mem_data_in[511:480]), 512'(32'h1F));

        do_write(32'h0000_0084, 32'hDEADBEEF, "T2 wr");
        do_read(32'h0000_0080, 1'b0, 0, "T2 rd");
        chk("T2 words", 512'(main_mem_data_in[95:0]), 512'({32'h22, 32'hDEADBEEF, 32'h20}));

        do_read(32'h0001_0000, 1'b0, 0, "T3 alias");
        do_read(32'h0000_007F, 1'b0, 0, "T3 unaligned");
        chk("T3 word0", 512'(main_mem_data_in[31:0]), 512'(32'h10));

        do_read(32'h0000_0040, 1'b1, 0, "T4 both");
        do_read(32'h0000_0040, 1'b0, 0, "T4 reread");
        chk("T4 word0", 512'(main_mem_data_in[31:0]), 512'(32'h10));

        do_read(32'h0000_0040, 1'b0, 17, "T5 busy req");

        // Reset in the middle of a line fill.
        @(negedge clk);
        main_mem_addr = 32'h0000_0100;
        main_mem_read_req = 1'b1;
        @(negedge clk);
        main_mem_read_req = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("T6 async reset", {main_mem_data_in, main_mem_ready, busy, protocol_err}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        r0 = rdy_cnt;
        repeat (30) @(negedge clk);
        #1;
        chk("T6 no ready", 512'(rdy_cnt - r0), 512'(0));
        last_line = '0;
        do_read(32'h0000_0040, 1'b0, 0, "T6 rd");

        for (int t = 0; t < 24; t++) begin
            a = $urandom() & 32'hFFFF_C3FF;
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom();
                do_write(a, d, "RND wr");
            end else begin
                do_read(a, 1'b0, 0, "RND rd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
